mem_bus_arbiter: RTL

Two-port arbiter and sequencer for the single shared 8-bit RAM. Requester A is the CPU fetch/stack/MOV path; requester B is the DMA/program-loader port. It serialises accesses with round-robin fairness and drives the RAM enable, write and address strobes. It generates the per-requester ready pulse; the CPU side feeds cpu_ctrl's bus_ready.

---
 rtl/mem_bus_arbiter_pkg.sv | 23 ++
 rtl/mem_bus_arbiter_if.sv | 43 ++++
 rtl/mem_bus_arbiter_rr_arb2.sv | 23 ++
 rtl/mem_bus_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the mem_bus_arbiter slice: FSM states, grant owner, perf counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_DMA
    } owner_t;

    localparam int unsigned PERF_W = 16;

    // Saturating increment used by the optional performance counters.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + PERF_W'(1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of requester handshakes and RAM strobes around mem_bus_arbiter.
// slave: the arbiter's view. master: the requesters and RAM seen from outside.
interface mem_bus_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ready;
    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_ready;
    logic [DW-1:0] rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          owner_dma;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_ready, dma_ready, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy, owner_dma
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_ready, dma_ready, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy, owner_dma
    );
endinterface

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// rr_arb2: combinational two-input round-robin pick. Side A is the CPU, side B the DMA.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic   req_a,
    input  logic   req_b,
    input  owner_t last_grant,
    output logic   gnt_valid,
    output owner_t gnt_sel
);

    // A lone request wins outright; on a tie the side not granted last time wins.
    always_comb begin
        gnt_valid = req_a | req_b;
        gnt_sel   = OWN_CPU;
        if (req_a && req_b) begin
            gnt_sel = (last_grant == OWN_CPU) ? OWN_DMA : OWN_CPU;
        end else if (req_b) begin
            gnt_sel = OWN_DMA;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: serialises CPU and DMA accesses to the shared RAM with round-robin
// fairness, sequences the RAM strobes and returns a one-cycle ready to the owner.
// Optional build macro MEM_ARB_PERF_EN adds saturating completion/stall counters.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 8,
    parameter int unsigned RAM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_cycle,
    mem_bus_arbiter_if.slave  bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_cpu_cnt,
    output logic [PERF_W-1:0] perf_dma_cnt,
    output logic [PERF_W-1:0] perf_stall_cnt
`endif
);

    // Wide enough for RAM_LAT-1 with RAM_LAT up to 7.
    localparam int unsigned CntW = 3;

    arb_state_t    state_q, state_d;
    owner_t        last_grant_q, last_grant_d;
    logic          owner_dma_q, owner_dma_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic   gnt_valid;
    owner_t gnt_sel;

    rr_arb2 u_rr_arb2 (
        .req_a      (bus.cpu_req),
        .req_b      (bus.dma_req),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_sel    (gnt_sel)
    );

    // Next-state logic: grant in IDLE, one issue cycle, optional latency wait, one ready cycle.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_dma_d  = owner_dma_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d      = ISSUE;
                    last_grant_d = gnt_sel;
                    owner_dma_d  = (gnt_sel == OWN_DMA);
                    if (gnt_sel == OWN_DMA) begin
                        we_d    = bus.dma_we;
                        addr_d  = bus.dma_addr;
                        wdata_d = bus.dma_wdata;
                    end else begin
                        we_d    = bus.cpu_we;
                        addr_d  = bus.cpu_addr;
                        wdata_d = bus.cpu_wdata;
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = DONE;
                end else if (RAM_LAT == 1) begin
                    rdata_d = bus.mem_rdata;
                    state_d = DONE;
                end else begin
                    cnt_d   = CntW'(RAM_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    rdata_d = bus.mem_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched-access registers; reset abandons any access without a ready.
    always_ff @(posedge clk or posedge reset_cycle) begin
        if (reset_cycle) begin
            state_q      <= IDLE;
            last_grant_q <= OWN_DMA;
            owner_dma_q  <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_dma_q  <= owner_dma_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
        end
    end

    // Strobes decode from state only, so ready and mem_en can never overlap.
    always_comb begin
        bus.mem_en    = (state_q == ISSUE);
        bus.mem_we    = (state_q == ISSUE) && we_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.rdata     = rdata_q;
        bus.cpu_ready = (state_q == DONE) && !owner_dma_q;
        bus.dma_ready = (state_q == DONE) && owner_dma_q;
        bus.busy      = (state_q != IDLE);
        bus.owner_dma = owner_dma_q;
    end

`ifdef MEM_ARB_PERF_EN
    logic [PERF_W-1:0] perf_cpu_cnt_q, perf_cpu_cnt_d;
    logic [PERF_W-1:0] perf_dma_cnt_q, perf_dma_cnt_d;
    logic [PERF_W-1:0] perf_stall_cnt_q, perf_stall_cnt_d;
    logic              cpu_stall, dma_stall;

    // A raised request stalls unless its owner is mid-access; waiting in IDLE counts too.
    always_comb begin
        cpu_stall        = bus.cpu_req && !((state_q != IDLE) && !owner_dma_q);
        dma_stall        = bus.dma_req && !((state_q != IDLE) && owner_dma_q);
        perf_cpu_cnt_d   = perf_cpu_cnt_q;
        perf_dma_cnt_d   = perf_dma_cnt_q;
        perf_stall_cnt_d = perf_stall_cnt_q;
        if (state_q == DONE && !owner_dma_q) perf_cpu_cnt_d = sat_inc(perf_cpu_cnt_q);
        if (state_q == DONE && owner_dma_q)  perf_dma_cnt_d = sat_inc(perf_dma_cnt_q);
        if (cpu_stall || dma_stall)          perf_stall_cnt_d = sat_inc(perf_stall_cnt_q);
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge reset_cycle) begin
        if (reset_cycle) begin
            perf_cpu_cnt_q   <= '0;
            perf_dma_cnt_q   <= '0;
            perf_stall_cnt_q <= '0;
        end else begin
            perf_cpu_cnt_q   <= perf_cpu_cnt_d;
            perf_dma_cnt_q   <= perf_dma_cnt_d;
            perf_stall_cnt_q <= perf_stall_cnt_d;
        end
    end

    assign perf_cpu_cnt   = perf_cpu_cnt_q;
    assign perf_dma_cnt   = perf_dma_cnt_q;
    assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule
